iommu_ds_mem_responder: RTL and testbench

//   AXI4 slave responder for the IOMMU data-structure master port (ds_req_o / ds_resp_i).

---
 rtl/iommu_ds_mem_responder.sv | 329 ++++++++++++++++++++++++++++++++
 tb/tb_iommu_ds_mem_responder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iommu_ds_mem_responder.sv
// AXI4 slave backing store for the IOMMU data-structure port: serves table reads and queue
// writes from a word-addressed memory. Read and write channels run independently, one burst each.
module iommu_ds_mem_responder #(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    DATA_WIDTH = 64,
    parameter int                    ID_WIDTH   = 4,
    parameter int                    MEM_WORDS  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h8000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ar_valid_i,
    output logic                  ar_ready_o,
    input  logic [ID_WIDTH-1:0]   ar_id_i,
    input  logic [ADDR_WIDTH-1:0] ar_addr_i,
    input  logic [7:0]            ar_len_i,
    input  logic [2:0]            ar_size_i,
    input  logic [1:0]            ar_burst_i,
    output logic                  r_valid_o,
    input  logic                  r_ready_i,
    output logic [ID_WIDTH-1:0]   r_id_o,
    output logic [DATA_WIDTH-1:0] r_data_o,
    output logic [1:0]            r_resp_o,
    output logic                  r_last_o,
    input  logic                  aw_valid_i,
    output logic                  aw_ready_o,
    input  logic [ID_WIDTH-1:0]   aw_id_i,
    input  logic [ADDR_WIDTH-1:0] aw_addr_i,
    input  logic [7:0]            aw_len_i,
    input  logic [2:0]            aw_size_i,
    input  logic [1:0]            aw_burst_i,
    input  logic                  w_valid_i,
    output logic                  w_ready_o,
    input  logic [DATA_WIDTH-1:0] w_data_i,
    input  logic [7:0]            w_strb_i,
    input  logic                  w_last_i,
    output logic                  b_valid_o,
    input  logic                  b_ready_i,
    output logic [ID_WIDTH-1:0]   b_id_o,
    output logic [1:0]            b_resp_o
);

    localparam int         IDX_W       = $clog2(MEM_WORDS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;

    if (DATA_WIDTH != 64) begin : g_bad_data_width
        $error("iommu_ds_mem_responder only supports DATA_WIDTH = 64");
    end

    typedef enum logic {RD_IDLE, RD_BURST} rd_state_e;
    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_e;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    // Returns {resp, word index}; BASE_ADDR is 8-byte aligned so offset[2:0] equals addr[2:0].
    function automatic logic [IDX_W+1:0] beat_check(input logic [ADDR_WIDTH-1:0] addr,
                                                    input logic [2:0]            size,
                                                    input logic [1:0]            burst);
        logic [ADDR_WIDTH-1:0] offset;
        logic [1:0]            resp;
        offset = addr - BASE_ADDR;
        if (size != 3'd3 || burst[1] || offset[2:0] != 3'b000) begin
            resp = RESP_SLVERR;
        end else if (addr < BASE_ADDR || offset[ADDR_WIDTH-1:IDX_W+3] != '0) begin
            resp = RESP_DECERR;
        end else begin
            resp = RESP_OKAY;
        end
        return {resp, offset[IDX_W+2:3]};
    endfunction

    function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
        if (a == RESP_SLVERR || b == RESP_SLVERR) return RESP_SLVERR;
        if (a == RESP_DECERR || b == RESP_DECERR) return RESP_DECERR;
        return RESP_OKAY;
    endfunction

    rd_state_e             rd_state_q, rd_state_d;
    logic [ID_WIDTH-1:0]   rd_id_q, rd_id_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [7:0]            rd_len_q, rd_len_d;
    logic [2:0]            rd_size_q, rd_size_d;
    logic [1:0]            rd_burst_q, rd_burst_d;
    logic [7:0]            rd_beat_q, rd_beat_d;
    logic                  ar_ready_q, ar_ready_d;
    logic                  r_valid_q, r_valid_d;
    logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic [1:0]            r_resp_q, r_resp_d;
    logic                  r_last_q, r_last_d;

    logic [ADDR_WIDTH-1:0] rd_next_addr, rd_lk_addr;
    logic [2:0]            rd_lk_size;
    logic [1:0]            rd_lk_burst, rd_lk_resp;
    logic [IDX_W-1:0]      rd_lk_idx;
    logic [DATA_WIDTH-1:0] rd_lk_data;

    // One lookup port: the AR address while idle, otherwise the following beat's address.
    always_comb begin
        rd_next_addr = (rd_burst_q == BURST_FIXED) ? rd_addr_q : rd_addr_q + ADDR_WIDTH'(8);
        rd_lk_addr   = (rd_state_q == RD_IDLE) ? ar_addr_i  : rd_next_addr;
        rd_lk_size   = (rd_state_q == RD_IDLE) ? ar_size_i  : rd_size_q;
        rd_lk_burst  = (rd_state_q == RD_IDLE) ? ar_burst_i : rd_burst_q;
        {rd_lk_resp, rd_lk_idx} = beat_check(rd_lk_addr, rd_lk_size, rd_lk_burst);
        rd_lk_data   = (rd_lk_resp == RESP_OKAY) ? mem[rd_lk_idx] : '0;
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_id_d    = rd_id_q;
        rd_addr_d  = rd_addr_q;
        rd_len_d   = rd_len_q;
        rd_size_d  = rd_size_q;
        rd_burst_d = rd_burst_q;
        rd_beat_d  = rd_beat_q;
        ar_ready_d = ar_ready_q;
        r_valid_d  = r_valid_q;
        r_data_d   = r_data_q;
        r_resp_d   = r_resp_q;
        r_last_d   = r_last_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (ar_valid_i && ar_ready_q) begin
                    rd_id_d    = ar_id_i;
                    rd_addr_d  = ar_addr_i;
                    rd_len_d   = ar_len_i;
                    rd_size_d  = ar_size_i;
                    rd_burst_d = ar_burst_i;
                    rd_beat_d  = 8'd0;
                    ar_ready_d = 1'b0;
                    r_valid_d  = 1'b1;
                    r_data_d   = rd_lk_data;
                    r_resp_d   = rd_lk_resp;
                    r_last_d   = (ar_len_i == 8'd0);
                    rd_state_d = RD_BURST;
                end
            end
            RD_BURST: begin
                if (r_valid_q && r_ready_i) begin
                    if (r_last_q) begin
                        r_valid_d  = 1'b0;
                        r_data_d   = '0;
                        r_resp_d   = RESP_OKAY;
                        r_last_d   = 1'b0;
                        ar_ready_d = 1'b1;
                        rd_state_d = RD_IDLE;
                    end else begin
                        rd_addr_d = rd_next_addr;
                        rd_beat_d = rd_beat_q + 8'd1;
                        r_data_d  = rd_lk_data;
                        r_resp_d  = rd_lk_resp;
                        r_last_d  = ((rd_beat_q + 8'd1) == rd_len_q);
                    end
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_state_q <= RD_IDLE;
            rd_id_q    <= '0;
            rd_addr_q  <= '0;
            rd_len_q   <= '0;
            rd_size_q  <= '0;
            rd_burst_q <= '0;
            rd_beat_q  <= '0;
            ar_ready_q <= 1'b1;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= '0;
            r_last_q   <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_id_q    <= rd_id_d;
            rd_addr_q  <= rd_addr_d;
            rd_len_q   <= rd_len_d;
            rd_size_q  <= rd_size_d;
            rd_burst_q <= rd_burst_d;
            rd_beat_q  <= rd_beat_d;
            ar_ready_q <= ar_ready_d;
            r_valid_q  <= r_valid_d;
            r_data_q   <= r_data_d;
            r_resp_q   <= r_resp_d;
            r_last_q   <= r_last_d;
        end
    end

    wr_state_e             wr_state_q, wr_state_d;
    logic [ID_WIDTH-1:0]   wr_id_q, wr_id_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]            wr_len_q, wr_len_d;
    logic [2:0]            wr_size_q, wr_size_d;
    logic [1:0]            wr_burst_q, wr_burst_d;
    logic [7:0]            wr_beat_q, wr_beat_d;
    logic [1:0]            wr_err_q, wr_err_d;
    logic                  aw_ready_q, aw_ready_d;
    logic                  w_ready_q, w_ready_d;
    logic                  b_valid_q, b_valid_d;
    logic [ID_WIDTH-1:0]   b_id_q, b_id_d;
    logic [1:0]            b_resp_q, b_resp_d;

    logic [1:0]            wr_beat_resp, wr_merged;
    logic [IDX_W-1:0]      wr_idx;
    logic                  w_fire, wr_beat_last, mem_we;

    always_comb begin
        {wr_beat_resp, wr_idx} = beat_check(wr_addr_q, wr_size_q, wr_burst_q);
        w_fire       = w_valid_i && w_ready_q;
        wr_beat_last = (wr_beat_q == wr_len_q);
        mem_we       = w_fire && (wr_beat_resp == RESP_OKAY);
        wr_merged    = worst(wr_err_q, wr_beat_resp);
        if (w_last_i != wr_beat_last) wr_merged = RESP_SLVERR;
    end

    always_comb begin
        wr_state_d = wr_state_q;
        wr_id_d    = wr_id_q;
        wr_addr_d  = wr_addr_q;
        wr_len_d   = wr_len_q;
        wr_size_d  = wr_size_q;
        wr_burst_d = wr_burst_q;
        wr_beat_d  = wr_beat_q;
        wr_err_d   = wr_err_q;
        aw_ready_d = aw_ready_q;
        w_ready_d  = w_ready_q;
        b_valid_d  = b_valid_q;
        b_id_d     = b_id_q;
        b_resp_d   = b_resp_q;
        case (wr_state_q)
            WR_IDLE: begin
                if (aw_valid_i && aw_ready_q) begin
                    wr_id_d    = aw_id_i;
                    wr_addr_d  = aw_addr_i;
                    wr_len_d   = aw_len_i;
                    wr_size_d  = aw_size_i;
                    wr_burst_d = aw_burst_i;
                    wr_beat_d  = 8'd0;
                    wr_err_d   = RESP_OKAY;
                    aw_ready_d = 1'b0;
                    w_ready_d  = 1'b1;
                    wr_state_d = WR_DATA;
                end
            end
            WR_DATA: begin
                // Whichever comes first, w_last or the final counted beat, closes the burst.
                if (w_fire) begin
                    if (w_last_i || wr_beat_last) begin
                        w_ready_d  = 1'b0;
                        b_valid_d  = 1'b1;
                        b_id_d     = wr_id_q;
                        b_resp_d   = wr_merged;
                        wr_state_d = WR_RESP;
                    end else begin
                        wr_err_d  = wr_merged;
                        wr_beat_d = wr_beat_q + 8'd1;
                        if (wr_burst_q != BURST_FIXED) wr_addr_d = wr_addr_q + ADDR_WIDTH'(8);
                    end
                end
            end
            WR_RESP: begin
                if (b_valid_q && b_ready_i) begin
                    b_valid_d  = 1'b0;
                    b_resp_d   = RESP_OKAY;
                    aw_ready_d = 1'b1;
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_state_q <= WR_IDLE;
            wr_id_q    <= '0;
            wr_addr_q  <= '0;
            wr_len_q   <= '0;
            wr_size_q  <= '0;
            wr_burst_q <= '0;
            wr_beat_q  <= '0;
            wr_err_q   <= '0;
            aw_ready_q <= 1'b1;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_id_q     <= '0;
            b_resp_q   <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_id_q    <= wr_id_d;
            wr_addr_q  <= wr_addr_d;
            wr_len_q   <= wr_len_d;
            wr_size_q  <= wr_size_d;
            wr_burst_q <= wr_burst_d;
            wr_beat_q  <= wr_beat_d;
            wr_err_q   <= wr_err_d;
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
            b_valid_q  <= b_valid_d;
            b_id_q     <= b_id_d;
            b_resp_q   <= b_resp_d;
        end
    end

    // Storage is deliberately not reset; a read in the same cycle sees the old word.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (w_strb_i[b]) mem[wr_idx][8*b +: 8] <= w_data_i[8*b +: 8];
            end
        end
    end

    assign ar_ready_o = ar_ready_q;
    assign r_valid_o  = r_valid_q;
    assign r_id_o     = rd_id_q;
    assign r_data_o   = r_data_q;
    assign r_resp_o   = r_resp_q;
    assign r_last_o   = r_last_q;
    assign aw_ready_o = aw_ready_q;
    assign w_ready_o  = w_ready_q;
    assign b_valid_o  = b_valid_q;
    assign b_id_o     = b_id_q;
    assign b_resp_o   = b_resp_q;

endmodule

// File: tb/tb_iommu_ds_mem_responder.sv
// Directed bench for iommu_ds_mem_responder: reset, data path, strobes, error responses,
// backpressure and reset during a read burst.
module tb_iommu_ds_mem_responder;

    localparam logic [63:0] BASE = 64'h8000_0000;

    logic        clk, rst;
    logic        ar_valid, ar_ready;
    logic [3:0]  ar_id;
    logic [63:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        r_valid, r_ready, r_last;
    logic [3:0]  r_id;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        aw_valid, aw_ready;
    logic [3:0]  aw_id;
    logic [63:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic        w_valid, w_ready, w_last;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        b_valid, b_ready;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;

    int checks = 0;
    int errors = 0;

    logic [63:0] wdata_v [8];
    logic [7:0]  wstrb_v [8];
    logic [63:0] rdata_v [8];
    logic [1:0]  rresp_v [8];
    logic        rlast_v [8];
    logic [3:0]  rid_v   [8];
    logic [1:0]  bresp_v;
    logic [3:0]  bid_v;

    iommu_ds_mem_responder dut (
        .clk_i(clk), .rst_i(rst),
        .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_id_i(ar_id), .ar_addr_i(ar_addr),
        .ar_len_i(ar_len), .ar_size_i(ar_size), .ar_burst_i(ar_burst),
        .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id), .r_data_o(r_data),
        .r_resp_o(r_resp), .r_last_o(r_last),
        .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_id_i(aw_id), .aw_addr_i(aw_addr),
        .aw_len_i(aw_len), .aw_size_i(aw_size), .aw_burst_i(aw_burst),
        .w_valid_i(w_valid), .w_ready_o(w_ready), .w_data_i(w_data), .w_strb_i(w_strb),
        .w_last_i(w_last),
        .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic timeout_fail(input string what);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out waiting, got no handshake, required one within 50 cycles", what);
    endtask

    // All helpers start and end 1 time unit after a rising edge.
    task automatic ar_send(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        ar_valid = 1'b1; ar_id = id; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst;
        while (ar_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) timeout_fail("ar_handshake");
        @(posedge clk); #1;
        ar_valid = 1'b0;
    endtask

    task automatic collect_beats(input int nbeats);
        r_ready = 1'b1;
        for (int i = 0; i < nbeats; i++) begin
            int n = 0;
            while (r_valid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
            if (n >= 50) timeout_fail("r_beat");
            rdata_v[i] = r_data; rresp_v[i] = r_resp; rlast_v[i] = r_last; rid_v[i] = r_id;
            @(posedge clk); #1;
        end
        r_ready = 1'b0;
    endtask

    task automatic axi_write(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input int nbeats, input int wlast_beat);
        int n = 0;
        aw_valid = 1'b1; aw_id = id; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst;
        while (aw_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) timeout_fail("aw_handshake");
        @(posedge clk); #1;
        aw_valid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            w_valid = 1'b1; w_data = wdata_v[i]; w_strb = wstrb_v[i]; w_last = (i == wlast_beat);
            n = 0;
            while (w_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
            if (n >= 50) timeout_fail("w_handshake");
            @(posedge clk); #1;
        end
        w_valid = 1'b0; w_last = 1'b0;
        b_ready = 1'b1;
        n = 0;
        while (b_valid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) timeout_fail("b_response");
        bresp_v = b_resp; bid_v = b_id;
        @(posedge clk); #1;
        b_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (ar_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ar_ready: got %b expected 1", ar_ready); end
        checks++; if (aw_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_aw_ready: got %b expected 1", aw_ready); end
        checks++; if (w_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_w_ready: got %b expected 0", w_ready); end
        checks++; if (r_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_r_valid: got %b expected 0", r_valid); end
        checks++; if (b_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_b_valid: got %b expected 0", b_valid); end
        checks++; if (r_data !== 64'h0) begin errors++; $display("[TB] FAIL reset_r_data: got %h expected 0", r_data); end
        checks++; if (b_resp !== 2'b00) begin errors++; $display("[TB] FAIL reset_b_resp: got %b expected 00", b_resp); end
    endtask

    task automatic test_write_read();
        wdata_v[0] = 64'hDEAD_BEEF_0123_4567; wstrb_v[0] = 8'hFF;
        axi_write(4'h3, BASE, 8'd0, 3'd3, 2'b01, 1, 0);
        checks++; if (bresp_v !== 2'b00) begin errors++; $display("[TB] FAIL wr_bresp: got %b expected 00", bresp_v); end
        checks++; if (bid_v !== 4'h3) begin errors++; $display("[TB] FAIL wr_bid: got %h expected 3", bid_v); end
        ar_send(4'h5, BASE, 8'd0, 3'd3, 2'b01);
        checks++; if (r_valid !== 1'b1) begin errors++; $display("[TB] FAIL rd_latency1: got r_valid %b expected 1", r_valid); end
        collect_beats(1);
        checks++; if (rdata_v[0] !== 64'hDEAD_BEEF_0123_4567) begin errors++; $display("[TB] FAIL rd_data: got %h expected deadbeef01234567", rdata_v[0]); end
        checks++; if (rresp_v[0] !== 2'b00) begin errors++; $display("[TB] FAIL rd_resp: got %b expected 00", rresp_v[0]); end
        checks++; if (rlast_v[0] !== 1'b1) begin errors++; $display("[TB] FAIL rd_last: got %b expected 1", rlast_v[0]); end
        checks++; if (rid_v[0] !== 4'h5) begin errors++; $display("[TB] FAIL rd_id: got %h expected 5", rid_v[0]); end
        checks++; if (ar_ready !== 1'b1) begin errors++; $display("[TB] FAIL rd_ar_ready_after: got %b expected 1", ar_ready); end
    endtask

    task automatic test_partial_strobe();
        wdata_v[0] = 64'h0; wstrb_v[0] = 8'hFF;
        axi_write(4'h1, BASE + 64'd8, 8'd0, 3'd3, 2'b01, 1, 0);
        wdata_v[0] = 64'hFFFF_FFFF_FFFF_FFFF; wstrb_v[0] = 8'h0F;
        axi_write(4'h1, BASE + 64'd8, 8'd0, 3'd3, 2'b01, 1, 0);
        ar_send(4'h1, BASE + 64'd8, 8'd0, 3'd3, 2'b01);
        collect_beats(1);
        checks++; if (rdata_v[0] !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("[TB] FAIL strobe_data: got %h expected 00000000ffffffff", rdata_v[0]); end
    endtask

    task automatic test_decerr_boundary();
        logic [63:0] exp_d [4];
        logic [1:0]  exp_r [4];
        exp_d = '{64'h1022_1022_1022_1022, 64'h1023_1023_1023_1023, 64'h0, 64'h0};
        exp_r = '{2'b00, 2'b00, 2'b11, 2'b11};
        wdata_v[0] = exp_d[0]; wstrb_v[0] = 8'hFF;
        wdata_v[1] = exp_d[1]; wstrb_v[1] = 8'hFF;
        axi_write(4'h2, BASE + 64'h1FF0, 8'd1, 3'd3, 2'b01, 2, 1);
        checks++; if (bresp_v !== 2'b00) begin errors++; $display("[TB] FAIL edge_wr_bresp: got %b expected 00", bresp_v); end
        ar_send(4'h2, BASE + 64'h1FF0, 8'd3, 3'd3, 2'b01);
        collect_beats(4);
        for (int i = 0; i < 4; i++) begin
            checks++; if (rdata_v[i] !== exp_d[i]) begin errors++; $display("[TB] FAIL edge_data beat %0d: got %h expected %h", i, rdata_v[i], exp_d[i]); end
            checks++; if (rresp_v[i] !== exp_r[i]) begin errors++; $display("[TB] FAIL edge_resp beat %0d: got %b expected %b", i, rresp_v[i], exp_r[i]); end
            checks++; if (rlast_v[i] !== (i == 3)) begin errors++; $display("[TB] FAIL edge_last beat %0d: got %b expected %b", i, rlast_v[i], (i == 3)); end
        end
    endtask

    task automatic test_slverr();
        ar_send(4'h4, BASE, 8'd1, 3'd2, 2'b01);
        collect_beats(2);
        for (int i = 0; i < 2; i++) begin
            checks++; if (rresp_v[i] !== 2'b10) begin errors++; $display("[TB] FAIL size_resp beat %0d: got %b expected 10", i, rresp_v[i]); end
            checks++; if (rdata_v[i] !== 64'h0) begin errors++; $display("[TB] FAIL size_data beat %0d: got %h expected 0", i, rdata_v[i]); end
        end
        checks++; if (rlast_v[1] !== 1'b1) begin errors++; $display("[TB] FAIL size_last: got %b expected 1", rlast_v[1]); end
        wdata_v[0] = 64'h0; wstrb_v[0] = 8'hFF;
        axi_write(4'h6, BASE, 8'd0, 3'd3, 2'b10, 1, 0);
        checks++; if (bresp_v !== 2'b10) begin errors++; $display("[TB] FAIL wrap_bresp: got %b expected 10", bresp_v); end
        ar_send(4'h6, BASE, 8'd0, 3'd3, 2'b01);
        collect_beats(1);
        checks++; if (rdata_v[0] !== 64'hDEAD_BEEF_0123_4567) begin errors++; $display("[TB] FAIL wrap_mem_unchanged: got %h expected deadbeef01234567", rdata_v[0]); end
    endtask

    task automatic test_wlast_mismatch();
        wdata_v[0] = 64'hAAAA_AAAA_AAAA_AAAA; wstrb_v[0] = 8'hFF;
        axi_write(4'h7, BASE + 64'h200, 8'd1, 3'd3, 2'b01, 1, 0);
        checks++; if (bresp_v !== 2'b10) begin errors++; $display("[TB] FAIL early_last_bresp: got %b expected 10", bresp_v); end
        checks++; if (aw_ready !== 1'b1) begin errors++; $display("[TB] FAIL early_last_aw_ready: got %b expected 1", aw_ready); end
        wdata_v[0] = 64'hBBBB_BBBB_BBBB_BBBB; wstrb_v[0] = 8'hFF;
        axi_write(4'h7, BASE + 64'h208, 8'd0, 3'd3, 2'b01, 1, -1);
        checks++; if (bresp_v !== 2'b10) begin errors++; $display("[TB] FAIL missing_last_bresp: got %b expected 10", bresp_v); end
        ar_send(4'h7, BASE + 64'h200, 8'd1, 3'd3, 2'b01);
        collect_beats(2);
        checks++; if (rdata_v[0] !== 64'hAAAA_AAAA_AAAA_AAAA) begin errors++; $display("[TB] FAIL early_last_data: got %h expected aaaaaaaaaaaaaaaa", rdata_v[0]); end
        checks++; if (rdata_v[1] !== 64'hBBBB_BBBB_BBBB_BBBB) begin errors++; $display("[TB] FAIL missing_last_data: got %h expected bbbbbbbbbbbbbbbb", rdata_v[1]); end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp_d [4];
        int n = 0;
        exp_d = '{64'hC0DE_0000_0000_0000, 64'hC0DE_0000_0000_0001,
                  64'hC0DE_0000_0000_0002, 64'hC0DE_0000_0000_0003};
        for (int i = 0; i < 4; i++) begin wdata_v[i] = exp_d[i]; wstrb_v[i] = 8'hFF; end
        axi_write(4'h8, BASE + 64'h100, 8'd3, 3'd3, 2'b01, 4, 3);
        ar_send(4'h8, BASE + 64'h100, 8'd3, 3'd3, 2'b01);
        r_ready = 1'b1;
        while (r_valid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) timeout_fail("bp_first_beat");
        checks++; if (r_data !== exp_d[0]) begin errors++; $display("[TB] FAIL bp_beat0: got %h expected %h", r_data, exp_d[0]); end
        @(posedge clk); #1;
        r_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (r_valid !== 1'b1 || r_data !== exp_d[1] || r_last !== 1'b0 || r_resp !== 2'b00) begin
                errors++;
                $display("[TB] FAIL bp_hold cycle %0d: got valid %b data %h last %b resp %b expected 1 %h 0 00",
                         c, r_valid, r_data, r_last, r_resp, exp_d[1]);
            end
        end
        r_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (r_valid !== 1'b1 || r_data !== exp_d[i] || r_last !== (i == 3)) begin
                errors++;
                $display("[TB] FAIL bp_beat %0d: got valid %b data %h last %b expected 1 %h %b",
                         i, r_valid, r_data, r_last, exp_d[i], (i == 3));
            end
            @(posedge clk); #1;
        end
        r_ready = 1'b0;
        checks++; if (r_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_no_extra_beat: got %b expected 0", r_valid); end
    endtask

    task automatic test_reset_mid_burst();
        ar_send(4'h9, BASE + 64'h100, 8'd7, 3'd3, 2'b01);
        collect_beats(3);
        checks++; if (r_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_beat3_valid: got %b expected 1", r_valid); end
        rst = 1'b1;
        #1;
        checks++; if (r_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_r_valid: got %b expected 0", r_valid); end
        @(posedge clk); #1;
        rst = 1'b0;
        r_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++; if (r_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_after_r_valid cycle %0d: got %b expected 0", c, r_valid); end
        end
        r_ready = 1'b0;
        checks++; if (ar_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_after_ar_ready: got %b expected 1", ar_ready); end
        ar_send(4'hA, BASE, 8'd0, 3'd3, 2'b01);
        collect_beats(1);
        checks++; if (rdata_v[0] !== 64'hDEAD_BEEF_0123_4567) begin errors++; $display("[TB] FAIL mid_after_read: got %h expected deadbeef01234567", rdata_v[0]); end
    endtask

    initial begin
        rst = 1'b1;
        ar_valid = 0; ar_id = 0; ar_addr = 0; ar_len = 0; ar_size = 0; ar_burst = 0;
        r_ready = 0;
        aw_valid = 0; aw_id = 0; aw_addr = 0; aw_len = 0; aw_size = 0; aw_burst = 0;
        w_valid = 0; w_data = 0; w_strb = 0; w_last = 0;
        b_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_write_read();
        test_partial_strobe();
        test_decerr_boundary();
        test_slverr();
        test_wlast_mismatch();
        test_backpressure();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
